// File: rtl/host_mem_bridge.sv
// host_mem_bridge: byte-serial host port and arbiter for the CPU's single-port 32-bit data RAM.
// Latency: host write hits RAM 1 cycle after the 4th byte; a host read streams bytes 3..6 cycles after the request.
// Backpressure: none toward the host. A request made while busy is dropped and flagged on host_err.
//   The CPU always wins the RAM port, except when the optional starvation guard forces a host slot.
// Ports: clk/rst_n; host_wr_valid/host_byte_in/host_addr/host_rd_req in; host_byte_out/host_byte_valid/
//        host_busy/host_err out; cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_gnt out;
//        mem_we/mem_addr/mem_wdata out, mem_rdata in (one-cycle read latency).
// Build option: define HOST_MEM_BRIDGE_STARVE_EN to enable the starvation counter and forced host slot.
module host_mem_bridge #(
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_wr_valid,
  input  logic [7:0]        host_byte_in,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_rd_req,
  output logic [7:0]        host_byte_out,
  output logic              host_byte_valid,
  output logic              host_busy,
  output logic              host_err,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  if (STARVE_LIMIT < 1) begin : g_limit_chk
    $error("host_mem_bridge: STARVE_LIMIT must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_WAIT, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       shift_q, shift_d;
  logic [1:0]        shift_cnt_q, shift_cnt_d;
  logic              err_q, err_d;
  logic              host_want;
  logic              host_slot;

  // The host only competes for the RAM port while it has a write or read address to issue.
  assign host_want = (state_q == WR) || (state_q == RD_ADDR);

`ifdef HOST_MEM_BRIDGE_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q;
  logic             starved;

  assign starved   = (starve_q == CNT_W'(STARVE_LIMIT));
  assign host_slot = host_want && (!cpu_req || starved);

  // Counts consecutive denied cycles; it never passes STARVE_LIMIT because
  // reaching the limit forces the slot, which clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (!host_want || host_slot) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  assign host_slot = host_want && !cpu_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      shift_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      shift_q     <= shift_d;
      shift_cnt_q <= shift_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    addr_d      = addr_q;
    shift_d     = shift_q;
    shift_cnt_d = shift_cnt_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (host_wr_valid) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = host_byte_in;
          byte_cnt_d = byte_cnt_q + 2'd1;  // wraps to 0 on the 4th byte
          if (byte_cnt_q == 2'd3) begin
            addr_d  = host_addr;
            state_d = WR;
          end
          // A simultaneous read request loses to the byte.
          if (host_rd_req) err_d = 1'b1;
        end else if (host_rd_req) begin
          if (byte_cnt_q == 2'd0) begin
            addr_d  = host_addr;
            state_d = RD_ADDR;
          end else begin
            err_d = 1'b1;  // partial word is kept
          end
        end
      end
      WR:      if (host_slot) state_d = IDLE;
      RD_ADDR: if (host_slot) state_d = RD_WAIT;
      RD_WAIT: begin
        shift_d     = mem_rdata;
        shift_cnt_d = 2'd0;
        state_d     = SHIFT;
      end
      SHIFT: begin
        shift_d     = {8'h00, shift_q[31:8]};
        shift_cnt_d = shift_cnt_q + 2'd1;
        if (shift_cnt_q == 2'd3) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && (host_wr_valid || host_rd_req)) err_d = 1'b1;
  end

  assign host_busy       = (state_q != IDLE);
  assign host_err        = err_q;
  assign host_byte_valid = (state_q == SHIFT);
  assign host_byte_out   = (state_q == SHIFT) ? shift_q[7:0] : 8'h00;

  // Port mux is purely combinational so a granted CPU access completes in the
  // same cycle. Qualified by rst_n so every output reads 0 while in reset.
  always_comb begin
    cpu_gnt   = rst_n && cpu_req && !host_slot;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_slot) begin
      mem_we    = (state_q == WR);
      mem_addr  = addr_q;
      mem_wdata = (state_q == WR) ? word_q : 32'h0;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

endmodule
